// File: rtl/dcache_write_buffer_pkg.sv
// rtl/dcache_write_buffer_pkg.sv - shared types and helpers for the D-cache store write buffer
package dcache_write_buffer_pkg;

  localparam int LINE_W = 29;
  localparam int MASK_W = 8;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_WORD  = 2'd1,
    SZ_DWORD = 2'd2,
    SZ_QWORD = 2'd3
  } size_e;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } entry_t;

  // Unshifted byte-enable pattern for a store size, widened to two lines.
  function automatic logic [2*MASK_W-1:0] size_mask(input logic [1:0] size);
    logic [2*MASK_W-1:0] m;
    case (size)
      SZ_BYTE:  m = 16'h0001;
      SZ_WORD:  m = 16'h0003;
      SZ_DWORD: m = 16'h000F;
      default:  m = 16'h00FF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dcache_write_buffer_store_align.sv
// rtl/dcache_write_buffer_store_align.sv - splits a store into one or two line-aligned byte-masked halves
module dcache_write_buffer_store_align
  import dcache_write_buffer_pkg::*;
(
  input  logic [31:0]       addr,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] data,
  output logic [LINE_W-1:0] lo_line,
  output logic [LINE_W-1:0] hi_line,
  output logic [DATA_W-1:0] lo_data,
  output logic [DATA_W-1:0] hi_data,
  output logic [MASK_W-1:0] lo_mask,
  output logic [MASK_W-1:0] hi_mask,
  output logic              split
);

  logic [2:0]          off;
  logic [2*MASK_W-1:0] mask_w;
  logic [2*DATA_W-1:0] data_w;

  // Shift data and byte enables into a two-line window; the upper line only matters when enabled.
  always_comb begin
    off     = addr[2:0];
    mask_w  = size_mask(size) << off;
    data_w  = {{DATA_W{1'b0}}, data} << {off, 3'b000};
    lo_line = addr[31:3];
    hi_line = addr[31:3] + LINE_W'(1);
    lo_data = data_w[DATA_W-1:0];
    hi_data = data_w[2*DATA_W-1:DATA_W];
    lo_mask = mask_w[MASK_W-1:0];
    hi_mask = mask_w[2*MASK_W-1:MASK_W];
    split   = |mask_w[2*MASK_W-1:MASK_W];
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - store FIFO between writeback and the D-cache data array
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WB_Final_Dcache_Write,
  input  logic [31:0]       WB_Final_Dcache_Address,
  input  logic [63:0]       WB_Final_Dcache_Data,
  input  logic [1:0]        WB_Final_datasize,
  output logic              In_write_ready,
  output logic              MEM_WR_REQ,
  output logic [LINE_W-1:0] MEM_WR_ADDR,
  output logic [DATA_W-1:0] MEM_WR_DATA,
  output logic [MASK_W-1:0] MEM_WR_MASK,
  input  logic              MEM_WR_ACK,
  input  logic [LINE_W-1:0] LD_CHECK_ADDR,
  output logic              LD_CONFLICT,
  output logic              WB_EMPTY
);

  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [LINE_W-1:0] lo_line, hi_line;
  logic [DATA_W-1:0] lo_data, hi_data;
  logic [MASK_W-1:0] lo_mask, hi_mask;
  logic              split;
  logic              push, pop;
  logic [PTR_W:0]    n_push;
  logic [PTR_W-1:0]  wr_ptr_nx;

  dcache_write_buffer_store_align u_align (
    .addr    (WB_Final_Dcache_Address),
    .size    (WB_Final_datasize),
    .data    (WB_Final_Dcache_Data),
    .lo_line (lo_line),
    .hi_line (hi_line),
    .lo_data (lo_data),
    .hi_data (hi_data),
    .lo_mask (lo_mask),
    .hi_mask (hi_mask),
    .split   (split)
  );

  // Handshake and head presentation come straight from registered state.
  always_comb begin
    In_write_ready = (count_q <= READY_MAX);
    MEM_WR_REQ     = (count_q != '0);
    WB_EMPTY       = (count_q == '0);
    MEM_WR_ADDR    = mem_q[rd_ptr_q].line;
    MEM_WR_DATA    = mem_q[rd_ptr_q].data;
    MEM_WR_MASK    = mem_q[rd_ptr_q].mask;
  end

  // Load hazard check over held entries only; the head counts even while being acked.
  always_comb begin
    LD_CONFLICT = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].line == LD_CHECK_ADDR)) LD_CONFLICT = 1'b1;
    end
  end

  // Next-state FIFO update: ready guarantees both halves land in free slots distinct from the head.
  always_comb begin
    push      = WB_Final_Dcache_Write && In_write_ready;
    pop       = MEM_WR_ACK && MEM_WR_REQ;
    wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    n_push    = '0;
    if (push) n_push = split ? (PTR_W+1)'(2) : (PTR_W+1)'(1);

    mem_d   = mem_q;
    valid_d = valid_q;
    if (pop) valid_d[rd_ptr_q] = 1'b0;
    if (push) begin
      mem_d[wr_ptr_q]   = '{line: lo_line, data: lo_data, mask: lo_mask};
      valid_d[wr_ptr_q] = 1'b1;
      if (split) begin
        mem_d[wr_ptr_nx]   = '{line: hi_line, data: hi_data, mask: hi_mask};
        valid_d[wr_ptr_nx] = 1'b1;
      end
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + n_push - (PTR_W+1)'(pop);
  end

  // State registers; reset discards every entry and clears storage so the head reads zero.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      mem_q    <= '{default: '0};
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - self-checking bench for dcache_write_buffer
module tb_dcache_write_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        WB_Final_Dcache_Write;
  logic [31:0] WB_Final_Dcache_Address;
  logic [63:0] WB_Final_Dcache_Data;
  logic [1:0]  WB_Final_datasize;
  logic        In_write_ready;
  logic        MEM_WR_REQ;
  logic [28:0] MEM_WR_ADDR;
  logic [63:0] MEM_WR_DATA;
  logic [7:0]  MEM_WR_MASK;
  logic        MEM_WR_ACK;
  logic [28:0] LD_CHECK_ADDR;
  logic        LD_CONFLICT;
  logic        WB_EMPTY;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [28:0] line;
    logic [63:0] data;
    logic [7:0]  mask;
  } ment_t;

  ment_t q[$];

  dcache_write_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .CLK                     (CLK),
    .CLR                     (CLR),
    .WB_Final_Dcache_Write   (WB_Final_Dcache_Write),
    .WB_Final_Dcache_Address (WB_Final_Dcache_Address),
    .WB_Final_Dcache_Data    (WB_Final_Dcache_Data),
    .WB_Final_datasize       (WB_Final_datasize),
    .In_write_ready          (In_write_ready),
    .MEM_WR_REQ              (MEM_WR_REQ),
    .MEM_WR_ADDR             (MEM_WR_ADDR),
    .MEM_WR_DATA             (MEM_WR_DATA),
    .MEM_WR_MASK             (MEM_WR_MASK),
    .MEM_WR_ACK              (MEM_WR_ACK),
    .LD_CHECK_ADDR           (LD_CHECK_ADDR),
    .LD_CONFLICT             (LD_CONFLICT),
    .WB_EMPTY                (WB_EMPTY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-by-byte placement of a store into the two-line window.
  task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [63:0] data);
    logic [7:0] bytes [16];
    logic       en    [16];
    int         off, nb;
    ment_t      lo, hi;
    logic       any_hi;
    for (int i = 0; i < 16; i++) begin bytes[i] = 8'h00; en[i] = 1'b0; end
    off = int'(addr[2:0]);
    nb  = 1 << size;
    for (int b = 0; b < 8; b++) begin
      bytes[off+b] = data[8*b +: 8];
      if (b < nb) en[off+b] = 1'b1;
    end
    lo.line = addr[31:3];
    hi.line = addr[31:3] + 29'd1;
    any_hi  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lo.data[8*i +: 8] = bytes[i];
      lo.mask[i]        = en[i];
      hi.data[8*i +: 8] = bytes[8+i];
      hi.mask[i]        = en[8+i];
      if (en[8+i]) any_hi = 1'b1;
    end
    q.push_back(lo);
    if (any_hi) q.push_back(hi);
  endtask

  // Reference model advances on each edge from the inputs and its own queue.
  always @(posedge CLK) begin
    if (!CLR) begin
      q.delete();
    end else begin
      logic acc;
      acc = WB_Final_Dcache_Write && (q.size() <= DEPTH - 2);
      if (MEM_WR_ACK && q.size() != 0) void'(q.pop_front());
      if (acc) model_store(WB_Final_Dcache_Address, WB_Final_datasize, WB_Final_Dcache_Data);
    end
  end

  // Every cycle out of reset, all outputs are compared against the model.
  always @(negedge CLK) begin
    if (CLR) begin
      logic conf;
      check("ready", {63'd0, In_write_ready}, {63'd0, q.size() <= DEPTH - 2});
      check("req", {63'd0, MEM_WR_REQ}, {63'd0, q.size() != 0});
      check("empty", {63'd0, WB_EMPTY}, {63'd0, q.size() == 0});
      if (q.size() != 0) begin
        check("head_addr", {35'd0, MEM_WR_ADDR}, {35'd0, q[0].line});
        check("head_data", MEM_WR_DATA, q[0].data);
        check("head_mask", {56'd0, MEM_WR_MASK}, {56'd0, q[0].mask});
      end
      conf = 1'b0;
      foreach (q[i]) if (q[i].line == LD_CHECK_ADDR) conf = 1'b1;
      check("conflict", {63'd0, LD_CONFLICT}, {63'd0, conf});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_store(input logic wr, input logic [31:0] addr, input logic [1:0] sz, input logic [63:0] data);
    WB_Final_Dcache_Write   = wr;
    WB_Final_Dcache_Address = addr;
    WB_Final_datasize       = sz;
    WB_Final_Dcache_Data    = data;
  endtask

  initial begin
    CLR = 1'b0;
    MEM_WR_ACK = 1'b0;
    LD_CHECK_ADDR = '0;
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    repeat (2) tick();
    check("rst_ready", {63'd0, In_write_ready}, 64'd1);
    check("rst_req", {63'd0, MEM_WR_REQ}, 64'd0);
    check("rst_conflict", {63'd0, LD_CONFLICT}, 64'd0);
    check("rst_empty", {63'd0, WB_EMPTY}, 64'd1);
    check("rst_addr", {35'd0, MEM_WR_ADDR}, 64'd0);
    check("rst_data", MEM_WR_DATA, 64'd0);
    check("rst_mask", {56'd0, MEM_WR_MASK}, 64'd0);
    CLR = 1'b1;
    tick();

    // byte store
    set_store(1'b1, 32'h1005, 2'd0, 64'hAB);
    tick();
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    #1;
    check("byte_req", {63'd0, MEM_WR_REQ}, 64'd1);
    check("byte_addr", {35'd0, MEM_WR_ADDR}, 64'h200);
    check("byte_mask", {56'd0, MEM_WR_MASK}, 64'h20);
    check("byte_data", MEM_WR_DATA, 64'h0000AB0000000000);
    MEM_WR_ACK = 1'b1;
    tick();
    MEM_WR_ACK = 1'b0;
    #1;
    check("byte_empty", {63'd0, WB_EMPTY}, 64'd1);

    // split store
    set_store(1'b1, 32'h100E, 2'd2, 64'h11223344);
    tick();
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    #1;
    check("split_addr0", {35'd0, MEM_WR_ADDR}, 64'h201);
    check("split_mask0", {56'd0, MEM_WR_MASK}, 64'hC0);
    check("split_data0", {48'd0, MEM_WR_DATA[63:48]}, 64'h3344);
    check("split_ready", {63'd0, In_write_ready}, 64'd1);
    MEM_WR_ACK = 1'b1;
    tick();
    #1;
    check("split_addr1", {35'd0, MEM_WR_ADDR}, 64'h202);
    check("split_mask1", {56'd0, MEM_WR_MASK}, 64'h03);
    check("split_data1", {48'd0, MEM_WR_DATA[15:0]}, 64'h1122);
    tick();
    MEM_WR_ACK = 1'b0;
    #1;
    check("split_empty", {63'd0, WB_EMPTY}, 64'd1);

    // fill with no acks
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h2000 + 32'(8*i), 2'd2, 64'hA0 + 64'(i));
      tick();
    end
    set_store(1'b1, 32'h2018, 2'd2, 64'hA3);
    #1;
    check("full_ready0", {63'd0, In_write_ready}, 64'd0);
    tick();
    #1;
    check("full_ready1", {63'd0, In_write_ready}, 64'd0);
    MEM_WR_ACK = 1'b1;
    tick();
    MEM_WR_ACK = 1'b0;
    #1;
    check("full_ready2", {63'd0, In_write_ready}, 64'd1);
    check("full_head", {35'd0, MEM_WR_ADDR}, 64'h401);
    tick();
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    #1;
    check("full_ready3", {63'd0, In_write_ready}, 64'd0);
    MEM_WR_ACK = 1'b1;
    repeat (4) tick();
    MEM_WR_ACK = 1'b0;
    #1;
    check("full_empty", {63'd0, WB_EMPTY}, 64'd1);

    // simultaneous push/pop at count 2 across pointer wrap
    set_store(1'b1, 32'h2800, 2'd3, 64'h1111);
    tick();
    set_store(1'b1, 32'h2808, 2'd3, 64'h2222);
    tick();
    MEM_WR_ACK = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_store(1'b1, 32'h3000 + 32'(8*i), 2'd3, 64'hC0DE0000 + 64'(i));
      tick();
      check("pp_ready", {63'd0, In_write_ready}, 64'd1);
    end
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    #1;
    check("pp_head", {35'd0, MEM_WR_ADDR}, 64'h604);
    repeat (2) tick();
    MEM_WR_ACK = 1'b0;
    #1;
    check("pp_empty", {63'd0, WB_EMPTY}, 64'd1);

    // conflict check
    LD_CHECK_ADDR = 29'h300;
    set_store(1'b1, 32'h1800, 2'd0, 64'h5A);
    #1;
    check("conf_same_cycle", {63'd0, LD_CONFLICT}, 64'd0);
    tick();
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    #1;
    check("conf_hit", {63'd0, LD_CONFLICT}, 64'd1);
    LD_CHECK_ADDR = 29'h301;
    #1;
    check("conf_miss", {63'd0, LD_CONFLICT}, 64'd0);
    LD_CHECK_ADDR = 29'h300;
    MEM_WR_ACK = 1'b1;
    #1;
    check("conf_acking", {63'd0, LD_CONFLICT}, 64'd1);
    tick();
    MEM_WR_ACK = 1'b0;
    #1;
    check("conf_after_ack", {63'd0, LD_CONFLICT}, 64'd0);

    // line-address wrap on a split store
    set_store(1'b1, 32'hFFFFFFFE, 2'd2, 64'hDEADBEEF);
    tick();
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    #1;
    check("wrap_line0", {35'd0, MEM_WR_ADDR}, 64'h1FFFFFFF);
    check("wrap_mask0", {56'd0, MEM_WR_MASK}, 64'hC0);
    MEM_WR_ACK = 1'b1;
    tick();
    #1;
    check("wrap_line1", {35'd0, MEM_WR_ADDR}, 64'h0);
    check("wrap_mask1", {56'd0, MEM_WR_MASK}, 64'h03);
    tick();
    MEM_WR_ACK = 1'b0;

    // mixed sizes/offsets checked only by the model
    set_store(1'b1, 32'h4003, 2'd3, 64'h0102030405060708);
    tick();
    set_store(1'b1, 32'h4107, 2'd1, 64'hBEEF);
    MEM_WR_ACK = 1'b1;
    tick();
    set_store(1'b1, 32'h4202, 2'd1, 64'h7777);
    tick();
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    repeat (5) tick();
    MEM_WR_ACK = 1'b0;

    // reset mid-drain
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h5000 + 32'(8*i), 2'd3, 64'hF0 + 64'(i));
      tick();
    end
    set_store(1'b0, 32'h0, 2'd0, 64'h0);
    MEM_WR_ACK = 1'b1;
    #2;
    CLR = 1'b0;
    q.delete();
    #1;
    check("clr_req", {63'd0, MEM_WR_REQ}, 64'd0);
    check("clr_ready", {63'd0, In_write_ready}, 64'd1);
    check("clr_empty", {63'd0, WB_EMPTY}, 64'd1);
    tick();
    CLR = 1'b1;
    tick();
    #1;
    check("clr_post_empty", {63'd0, WB_EMPTY}, 64'd1);
    check("clr_post_req", {63'd0, MEM_WR_REQ}, 64'd0);
    MEM_WR_ACK = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Consumer end of the writeback-stage D-cache store interface: accepts store requests and returns the write-ready handshake that stalls writeback.
- Each store is converted into one or two 8-byte-aligned, byte-masked entries and queued in a FIFO.
- Entries drain one at a time to the D-cache data array over a req/ack port.
- Provides a line-address conflict check so the memory stage can hold loads that hit a pending store.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- CLK  in  1  clock.
- CLR  in  1  asynchronous active-low reset.
- WB_Final_Dcache_Write  in  1  store request valid.
- WB_Final_Dcache_Address  in  32  store byte address.
- WB_Final_Dcache_Data  in  64  store data, right-justified.
- WB_Final_datasize  in  2  0=byte, 1=16b, 2=32b, 3=64b (MM).
- In_write_ready  out  1  buffer can accept a store this cycle.
- MEM_WR_REQ  out  1  head entry valid toward the D-cache array.
- MEM_WR_ADDR  out  29  head line address, addr[31:3].
- MEM_WR_DATA  out  64  head data, byte-lane aligned.
- MEM_WR_MASK  out  8  head byte enables.
- MEM_WR_ACK  in  1  array accepted the head entry.
- LD_CHECK_ADDR  in  29  load line address from the memory stage.
- LD_CONFLICT  out  1  a stored entry matches LD_CHECK_ADDR.
- WB_EMPTY  out  1  no entries held (used by halt drain).

Behaviour:
- Reset is asynchronous on CLR low.
  - Clears pointers, count and all valid bits.
  - Outputs after reset: In_write_ready=1, MEM_WR_REQ=0, LD_CONFLICT=0, WB_EMPTY=1.
  - MEM_WR_ADDR, MEM_WR_DATA and MEM_WR_MASK are 0.
  - A reset mid-drain discards all entries; any ack already in flight is ignored.
- In_write_ready = (count <= DEPTH-2).
  - It is derived only from registered count, never from same-cycle request inputs.
  - One accepted store can therefore always fit as two entries.
- A store is accepted on a rising CLK edge when WB_Final_Dcache_Write and In_write_ready are both 1.
  - A request while not ready is not captured. Writeback holds its request; no loss and no duplication.
- Alignment of an accepted store:
  - off = addr[2:0]; nbytes = 1, 2, 4 or 8 for size 0..3.
  - The 16-bit mask is ((1<<nbytes)-1)<<off.
  - The 128-bit data is data<<(8*off).
  - Low half goes to an entry with line = addr[31:3]: data[63:0], mask[7:0].
  - If mask[15:8] != 0, a second entry is pushed behind it: line = addr[31:3]+1 (29-bit wrap), data[127:64], mask[15:8].
- Entries are pushed in the same edge.
  - Count increases by 1 or 2, minus 1 if a pop also occurs that edge.
  - Simultaneous push and pop is legal at any count.
- Drain:
  - MEM_WR_REQ = (count != 0). MEM_WR_ADDR, MEM_WR_DATA and MEM_WR_MASK present the head entry combinationally from storage.
  - The outputs stay stable until acknowledged.
  - MEM_WR_ACK with MEM_WR_REQ=1 pops the head at the edge; MEM_WR_ACK with MEM_WR_REQ=0 is ignored.
  - At most one entry is drained per cycle, so minimum store-to-array latency is 1 cycle after acceptance.
- Pointers wrap modulo DEPTH. Full is count==DEPTH and empty is count==0; pointer equality alone is not used.
- LD_CONFLICT is combinational.
  - It is the OR over valid entries of (entry line == LD_CHECK_ADDR).
  - It excludes a store being accepted in the same cycle.
  - It includes the head even when it is being acked that cycle.
- WB_EMPTY = (count == 0).

Decomposition:
- Shared package holds:
  - size encodings (SZ_BYTE=0, SZ_WORD=1, SZ_DWORD=2, SZ_QWORD=3),
  - LINE_W=29 and MASK_W=8,
  - the entry struct {line, data, mask}.
- One natural sub-module, store_align: purely combinational addr/size/data to two-half data/mask plus a split flag.
- The FIFO, counter, conflict compare and handshake stay in dcache_write_buffer.

Test Plan:
- Reset, then a byte store: addr=0x1005, size 0, data=0xAB → after 1 edge MEM_WR_REQ=1, ADDR=0x200, MASK=0x20, DATA=0x0000AB0000000000; ack → WB_EMPTY=1.
- Split store: addr=0x100E, size 2, data=0x11223344 → two entries:
  - line 0x201, mask 0xC0, data[63:48]=0x3344;
  - then line 0x202, mask 0x03, data[15:0]=0x1122;
  - count goes 0→2.
- Fill with ACK=0 and DEPTH=4: aligned dword stores accepted at count 0, 1, 2. In_write_ready=0 at count 3; a held request is not captured until one ack, then accepted.
- Simultaneous push and pop at count 2 with an aligned store → count stays 2 and FIFO order is preserved across pointer wrap (push 6 stores, verify ack order).
- Conflict: entry line 0x300 queued, LD_CHECK_ADDR=0x300 → LD_CONFLICT=1; 0x301 → 0; after ack of that entry → 0.
- CLR low mid-drain with 3 entries and ACK high → immediately MEM_WR_REQ=0, In_write_ready=1, WB_EMPTY=1; no pop is counted after release.
